spi_master_engine: RTL

Serial shift engine of the AXI-to-SPI bridge. It sits between the register/AXI front end and the SPI pins, directly upstream of the SPI slave the bench models with its SPI slave agent. It accepts one transmit word per transfer through a valid/ready handshake and runs a full-duplex SPI frame in the selected CPOL/CPHA mode, with a programmable SCLK divider. It returns the captured MISO word with a one-cycle valid pulse.

---
 rtl/spi_master_engine.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/spi_master_engine.sv
// Full-duplex SPI shift engine with CPOL/CPHA modes and a programmable SCLK divider.
// Accepts one word per valid/ready handshake and returns the captured MISO word with a one-cycle pulse.
module spi_master_engine #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              ss_n
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EW-1:0]       edge_q, edge_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                ss_n_q, ss_n_d;
  logic                busy_q, busy_d;
  logic                start_ready_q, start_ready_d;
  logic                rx_valid_q, rx_valid_d;
  logic                half_done;
  logic                leading;

  assign half_done = (cnt_q == '0);
  // edge_q counts completed edges, so the upcoming edge is leading when the count is even
  assign leading   = ~edge_q[0];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_d         = div_q;
    edge_d        = edge_q;
    tx_sr_d       = tx_sr_q;
    rx_sr_d       = rx_sr_q;
    rx_data_d     = rx_data_q;
    cpol_d        = cpol_q;
    cpha_d        = cpha_q;
    sclk_d        = sclk_q;
    mosi_d        = mosi_q;
    ss_n_d        = ss_n_q;
    busy_d        = busy_q;
    start_ready_d = start_ready_q;
    rx_valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (start_valid && start_ready_q) begin
          state_d       = SETUP;
          cpol_d        = cpol;
          cpha_d        = cpha;
          div_d         = clk_div;
          cnt_d         = clk_div;
          edge_d        = '0;
          rx_sr_d       = '0;
          ss_n_d        = 1'b0;
          busy_d        = 1'b1;
          start_ready_d = 1'b0;
          if (!cpha) begin
            mosi_d  = tx_data[DATA_W-1];
            tx_sr_d = {tx_data[DATA_W-2:0], 1'b0};
          end else begin
            tx_sr_d = tx_data;
          end
        end
      end

      SETUP: begin
        if (half_done) begin
          state_d = SHIFT;
          cnt_d   = div_q;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

      SHIFT: begin
        if (half_done) begin
          cnt_d  = div_q;
          sclk_d = ~sclk_q;
          edge_d = edge_q + EW'(1);
          // Sampling edge is leading for cpha=0 and trailing for cpha=1; the other edge launches mosi
          if (leading ^ cpha_q) begin
            rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
          end else if (edge_q != LAST_EDGE) begin
            mosi_d  = tx_sr_q[DATA_W-1];
            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
          end
          if (edge_q == LAST_EDGE) begin
            state_d = HOLD;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

      HOLD: begin
        sclk_d = cpol_q;
        if (half_done) begin
          state_d       = IDLE;
          rx_data_d     = rx_sr_q;
          rx_valid_d    = 1'b1;
          ss_n_d        = 1'b1;
          busy_d        = 1'b0;
          start_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      div_q         <= '0;
      edge_q        <= '0;
      tx_sr_q       <= '0;
      rx_sr_q       <= '0;
      rx_data_q     <= '0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      sclk_q        <= 1'b0;
      mosi_q        <= 1'b0;
      ss_n_q        <= 1'b1;
      busy_q        <= 1'b0;
      start_ready_q <= 1'b1;
      rx_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      edge_q        <= edge_d;
      tx_sr_q       <= tx_sr_d;
      rx_sr_q       <= rx_sr_d;
      rx_data_q     <= rx_data_d;
      cpol_q        <= cpol_d;
      cpha_q        <= cpha_d;
      sclk_q        <= sclk_d;
      mosi_q        <= mosi_d;
      ss_n_q        <= ss_n_d;
      busy_q        <= busy_d;
      start_ready_q <= start_ready_d;
      rx_valid_q    <= rx_valid_d;
    end
  end

  assign start_ready = start_ready_q;
  assign busy        = busy_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign sclk        = sclk_q;
  assign mosi        = mosi_q;
  assign ss_n        = ss_n_q;

endmodule
